// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO read port and sends each as an 8N1 UART frame on o_tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_en,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_dout,
    output logic       o_fifo_rd,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_byte_done
);
`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, DATA, STOP} state_t;
`endif
    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
    logic tc, pre, tx_d, rd_d, busy_d, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic par;
`endif
    assign tc  = cnt == CNT_W'(CLKS_PER_BIT - 1);
    assign pre = cnt == CNT_W'(CLKS_PER_BIT - 2);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_tx        <= 1'b1;
            o_fifo_rd   <= 1'b0;
            o_busy      <= 1'b0;
            o_byte_done <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= nxt;
            o_tx        <= tx_d;
            o_fifo_rd   <= rd_d;
            o_busy      <= busy_d;
            o_byte_done <= done_d;
            cnt         <= (state inside {IDLE, FETCH, LATCH} || tc) ? '0 : cnt + CNT_W'(1);
            idx         <= state == LATCH ? 3'd0 : (state == DATA && tc) ? idx + 3'd1 : idx;
            shift       <= state == LATCH ? i_fifo_dout : (state == DATA && tc) ? {1'b0, shift[7:1]} : shift;
`ifdef FIFO_UART_TX_PARITY_EN
            par         <= state == LATCH ? ^i_fifo_dout : par;
`endif
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (i_tx_en && !i_fifo_empty) ? FETCH : IDLE;
            FETCH:   nxt = LATCH;
            LATCH:   nxt = START;
            START:   nxt = tc ? DATA : START;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:    nxt = (tc && idx == 3'd7) ? PARITY : DATA;
            PARITY:  nxt = tc ? STOP : PARITY;
`else
            DATA:    nxt = (tc && idx == 3'd7) ? STOP : DATA;
`endif
            STOP:    nxt = tc ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are computed from the next state so the registered copies line up with the state.
    always_comb begin
        tx_d   = nxt == START ? 1'b0 : nxt == DATA ? ((state == DATA && tc) ? shift[1] : shift[0]) : 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        if (nxt == PARITY) tx_d = par;
`endif
        rd_d   = nxt == FETCH;
        busy_d = nxt != IDLE;
        done_d = state == STOP && pre;
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmit stage directly downstream of the 10-deep × 8-bit FIFO.
- Pops one byte at a time from the FIFO read port and serializes it as an 8N1 UART frame on o_tx.
- Sends clock/time characters to a host terminal.
- Holds o_tx idle-high whenever the FIFO is empty or transmission is disabled.

Parameters:
- CLKS_PER_BIT, 434, i_clk cycles per UART bit (50 MHz / 115200). Legal range is 2..65535.
- CNT_W, 16, width of the baud counter. Must be able to hold CLKS_PER_BIT-1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_tx_en  input  1  level; when high, the block may start new frames.
- i_fifo_empty  input  1  FIFO empty flag.
- i_fifo_dout  input  8  FIFO read data; valid the cycle after a read strobe is sampled.
- o_fifo_rd  output  1  FIFO read strobe; exactly one cycle per byte.
- o_tx  output  1  UART serial line; idle high.
- o_busy  output  1  high in every state except IDLE.
- o_byte_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, i_rst_n=0):
  - State=IDLE.
  - o_tx=1, o_fifo_rd=0, o_busy=0, o_byte_done=0.
  - Shift register=0, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately; the line returns high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, FETCH, LATCH, START, DATA, PARITY (PARITY_EN builds only), STOP.
- IDLE:
  - If i_tx_en=1 and i_fifo_empty=0, set o_fifo_rd<=1 and go to FETCH.
  - Otherwise stay; o_tx=1.
- FETCH:
  - o_fifo_rd is high for this one cycle.
  - Set o_fifo_rd<=0; go to LATCH.
- LATCH:
  - Capture i_fifo_dout into the 8-bit shift register.
  - Set o_tx<=0, clear the baud counter, go to START.
- Bit timing:
  - START, each DATA bit, PARITY and STOP each last exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1; the bit boundary is at terminal count.
- START: at terminal count, set o_tx<=shift[0] and go to DATA with bit index 0.
- DATA:
  - Bits are sent LSB first.
  - At each terminal count, shift right and increment the index.
  - After bit index 7 completes, go to STOP (or PARITY).
- STOP:
  - o_tx=1.
  - At terminal count, pulse o_byte_done for that cycle and go to IDLE.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- Back-to-back bytes: the mark gap between a stop bit and the next start bit is exactly 3 cycles (IDLE, FETCH, LATCH).
- i_tx_en deasserted mid-frame: the current frame completes normally; no new fetch starts.
- i_fifo_empty is only sampled in IDLE. The block never issues o_fifo_rd while empty, so the FIFO's zero-on-empty-read output never reaches the line.
- Counter and index are unsigned and never wrap mid-bit. The bit index is 3 bits wide and cleared on entry to START.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - After DATA bit 7, a PARITY state of CLKS_PER_BIT cycles drives even parity (XOR of the 8 data bits), then STOP.
  - Frame = 11 bit times.
- Undefined:
  - No PARITY state or parity logic is built; DATA goes straight to STOP.
  - Frame = 10 bit times.

Test Plan:
- Reset and idle: CLKS_PER_BIT=4, FIFO empty, i_tx_en=1 for 100 cycles -> o_tx=1, o_fifo_rd never asserted, o_busy=0.
- Single byte: FIFO model holding 0xA5, i_tx_en=1 -> one o_fifo_rd pulse.
  - o_tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
  - o_byte_done pulses on cycle 40 after START entry.
- Back-to-back: FIFO holding 0x31, 0x32, 0x33 -> three frames decode to 0x31, 0x32, 0x33.
  - Exactly 3 high cycles between each stop bit and the next start.
  - Three o_fifo_rd pulses in total.
- Enable gating: drop i_tx_en mid-frame of 0x55 with 0x66 queued -> 0x55 completes; no further o_fifo_rd until i_tx_en returns high, then 0x66 is sent.
- Async reset mid-DATA bit 3: pull i_rst_n low between clock edges -> o_tx=1 immediately, o_busy=0.
  - After release with FIFO still non-empty, a fresh fetch and full frame follow.
- Parity (FIFO_UART_TX_PARITY_EN defined): send 0x07 -> parity bit=1, frame of 44 cycles. Send 0x03 -> parity bit=0.
